// File: rtl/out_display_if.sv
// out_display_if: groups the output-register load bus and the display pins.
// The CPU side drives the load strobe and value and watches the display
// pins. The display side consumes the load strobe and drives the pins.
interface out_display_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic              clk_en;
  logic              i_load_enable;
  logic [WIDTH-1:0]  i_load_data;
  logic [6:0]        o_seg;
  logic [DIGITS-1:0] o_an;
  logic              o_busy;

  modport master (
    output clk_en,
    output i_load_enable,
    output i_load_data,
    input  o_seg,
    input  o_an,
    input  o_busy
  );

  modport slave (
    input  clk_en,
    input  i_load_enable,
    input  i_load_data,
    output o_seg,
    output o_an,
    output o_busy
  );
endinterface

// File: rtl/out_display.sv
// out_display: converts a binary value from the output register into BCD
// and scans it across a multiplexed active-low 7-segment display.
//
// Conversion is a serial double-dabble that takes one step per clk. A load
// that arrives while a conversion is running is parked in a one-deep pending
// slot. The newest value wins.
//
// Build option: define OUT_DISPLAY_BLANK_EN to blank leading-zero digits.
// Digit 0 is never blanked.
module out_display #(
  parameter int WIDTH    = 16,
  parameter int DIGITS   = 5,
  parameter int SCAN_DIV = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  out_display_if.slave bus
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int STEP_W = $clog2(WIDTH + 1);
  localparam int DIV_W  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    shift_q, shift_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [STEP_W-1:0]   stepCnt_q, stepCnt_d;
  logic                pendValid_q, pendValid_d;
  logic [WIDTH-1:0]    pendData_q, pendData_d;
  logic [BCD_W-1:0]    disp_q, disp_d;
  logic [BCD_W+WIDTH-1:0] dabbled;

  logic [DIV_W-1:0]    divCnt_q;
  logic [IDX_W-1:0]    digitIdx_q;
  logic [6:0]          seg_q;
  logic [DIGITS-1:0]   an_q;

  logic [3:0]          curNibble;
  logic                curBlank;
  logic                loadEvent;

  assign loadEvent = bus.clk_en && bus.i_load_enable;

  // One double-dabble step: bias every nibble >= 5 by 3, then shift the
  // {bcd, binary} pair left by one so the next binary bit enters the BCD.
  function automatic logic [BCD_W+WIDTH-1:0] dabbleStep(
    input logic [BCD_W-1:0] bcdIn,
    input logic [WIDTH-1:0] binIn
  );
    logic [BCD_W-1:0] adj;
    adj = bcdIn;
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end
    end
    return {adj, binIn} << 1;
  endfunction

  // Active-low {g,f,e,d,c,b,a} pattern. Non-decimal nibbles show nothing.
  function automatic logic [6:0] segPattern(input logic [3:0] nib);
    case (nib)
      4'd0:    segPattern = 7'b1000000;
      4'd1:    segPattern = 7'b1111001;
      4'd2:    segPattern = 7'b0100100;
      4'd3:    segPattern = 7'b0110000;
      4'd4:    segPattern = 7'b0011001;
      4'd5:    segPattern = 7'b0010010;
      4'd6:    segPattern = 7'b0000010;
      4'd7:    segPattern = 7'b1111000;
      4'd8:    segPattern = 7'b0000000;
      4'd9:    segPattern = 7'b0010000;
      default: segPattern = 7'b1111111;
    endcase
  endfunction

  // Conversion FSM state register, scratch registers and the display register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bcd_q       <= '0;
      stepCnt_q   <= '0;
      pendValid_q <= 1'b0;
      pendData_q  <= '0;
      disp_q      <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bcd_q       <= bcd_d;
      stepCnt_q   <= stepCnt_d;
      pendValid_q <= pendValid_d;
      pendData_q  <= pendData_d;
      disp_q      <= disp_d;
    end
  end

  // Next-state logic: start, step, commit, and park late loads in pending.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bcd_d       = bcd_q;
    stepCnt_d   = stepCnt_q;
    pendValid_d = pendValid_q;
    pendData_d  = pendData_q;
    disp_d      = disp_q;
    dabbled     = '0;

    case (state_q)
      IDLE: begin
        // A fresh load is newer than anything still pending, so it wins.
        if (loadEvent) begin
          shift_d     = bus.i_load_data;
          bcd_d       = '0;
          stepCnt_d   = '0;
          pendValid_d = 1'b0;
          state_d     = CONVERT;
        end else if (pendValid_q) begin
          shift_d     = pendData_q;
          bcd_d       = '0;
          stepCnt_d   = '0;
          pendValid_d = 1'b0;
          state_d     = CONVERT;
        end
      end

      CONVERT: begin
        dabbled          = dabbleStep(bcd_q, shift_q);
        {bcd_d, shift_d} = dabbled;
        stepCnt_d        = stepCnt_q + STEP_W'(1);
        if (stepCnt_q == STEP_W'(WIDTH - 1)) begin
          state_d = COMMIT;
        end
        if (loadEvent) begin
          pendValid_d = 1'b1;
          pendData_d  = bus.i_load_data;
        end
      end

      COMMIT: begin
        disp_d = bcd_q;
        if (pendValid_q) begin
          shift_d     = pendData_q;
          bcd_d       = '0;
          stepCnt_d   = '0;
          pendValid_d = 1'b0;
          state_d     = CONVERT;
        end else begin
          state_d = IDLE;
        end
        // A load on this edge refills the slot that was just emptied.
        if (loadEvent) begin
          pendValid_d = 1'b1;
          pendData_d  = bus.i_load_data;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pick the nibble of the digit being scanned from the committed display.
  always_comb begin
    curNibble = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digitIdx_q == IDX_W'(i)) begin
        curNibble = disp_q[4*i +: 4];
      end
    end
  end

`ifdef OUT_DISPLAY_BLANK_EN
  // Blank the current digit if it and every digit above it are zero.
  always_comb begin
    logic seenNonZero;
    seenNonZero = 1'b0;
    curBlank    = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (disp_q[4*i +: 4] != 4'd0) begin
        seenNonZero = 1'b1;
      end
      if (digitIdx_q == IDX_W'(i)) begin
        curBlank = !seenNonZero;
      end
    end
  end
`else
  assign curBlank = 1'b0;
`endif

  // Scan divider, digit index, and registered segment/anode drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divCnt_q   <= '0;
      digitIdx_q <= '0;
      seg_q      <= 7'b1111111;
      an_q       <= '1;
    end else begin
      if (divCnt_q == DIV_W'(SCAN_DIV - 1)) begin
        divCnt_q <= '0;
        if (digitIdx_q == IDX_W'(DIGITS - 1)) begin
          digitIdx_q <= '0;
        end else begin
          digitIdx_q <= digitIdx_q + IDX_W'(1);
        end
      end else begin
        divCnt_q <= divCnt_q + DIV_W'(1);
      end
      an_q  <= ~(DIGITS'(1) << digitIdx_q);
      seg_q <= curBlank ? 7'b1111111 : segPattern(curNibble);
    end
  end

  assign bus.o_seg  = seg_q;
  assign bus.o_an   = an_q;
  assign bus.o_busy = (state_q != IDLE) || pendValid_q;

endmodule

// File: tb/tb_out_display.sv
// tb_out_display: directed table of load values with hand-computed BCD,
// plus sequences for reset, clk_en gating, pending loads and scan timing.
module tb_out_display;

  localparam int WIDTH    = 16;
  localparam int DIGITS   = 5;
  localparam int SCAN_DIV = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  out_display_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  out_display #(
    .WIDTH    (WIDTH),
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vecCount  = 0;
  int missCount = 0;

  typedef struct {
    logic [15:0] value;
    logic [19:0] expBcd;
  } vec_t;

  vec_t vecs [9];

  // Reference active-low segment codes for decimal digits.
  function automatic logic [6:0] segOf(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Returns the segment pattern expected on digit idx of a BCD display value.
  function automatic logic [6:0] expSegFor(input logic [19:0] bcd, input int idx);
    logic [19:0] upper;
    logic [3:0]  nib;
    upper = bcd >> (4 * idx);
    nib   = upper[3:0];
`ifdef OUT_DISPLAY_BLANK_EN
    if (idx > 0 && upper == 20'h0) return 7'b1111111;
`endif
    return segOf(nib);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // One-cycle load strobe, driven on the falling edge. Returns on the
  // falling edge after the capturing rising edge.
  task automatic applyStimulus(input logic [15:0] value, input logic en);
    @(negedge clk);
    bus.clk_en        = en;
    bus.i_load_enable = 1'b1;
    bus.i_load_data   = value;
    @(negedge clk);
    bus.i_load_enable = 1'b0;
    bus.clk_en        = 1'b0;
  endtask

  task automatic countBusy(output int n);
    n = 0;
    while (bus.o_busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Waits for each digit's scan slot and compares its segment pattern.
  task automatic checkDigits(input string name, input logic [19:0] expBcd);
    logic [4:0] expAn;
    int waited;
    for (int idx = 0; idx < DIGITS; idx++) begin
      expAn  = ~(5'b00001 << idx);
      waited = 0;
      while (bus.o_an !== expAn && waited < 100) begin
        @(negedge clk);
        waited++;
      end
      checkOutput($sformatf("%s an%0d", name, idx), {27'd0, bus.o_an}, {27'd0, expAn});
      checkOutput($sformatf("%s seg%0d", name, idx), {25'd0, bus.o_seg},
                  {25'd0, expSegFor(expBcd, idx)});
    end
  endtask

  initial begin
    int n;
    int cyc;
    int busyN;
    logic saw42;
    logic sawBusy;

    bus.clk_en        = 1'b0;
    bus.i_load_enable = 1'b0;
    bus.i_load_data   = '0;

    vecs[0] = '{16'd1234,  20'h01234};
    vecs[1] = '{16'd65535, 20'h65535};
    vecs[2] = '{16'd0,     20'h00000};
    vecs[3] = '{16'd7,     20'h00007};
    vecs[4] = '{16'd10,    20'h00010};
    vecs[5] = '{16'd100,   20'h00100};
    vecs[6] = '{16'd40960, 20'h40960};
    vecs[7] = '{16'd9999,  20'h09999};
    vecs[8] = '{16'd32768, 20'h32768};

    // Reset values while rst_n is held low.
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst seg",  {25'd0, bus.o_seg}, 32'h7F);
    checkOutput("rst an",   {27'd0, bus.o_an},  32'h1F);
    checkOutput("rst busy", {31'd0, bus.o_busy}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("first an",  {27'd0, bus.o_an},  32'h1E);
    checkOutput("first seg", {25'd0, bus.o_seg}, 32'h40);

    // Table of single loads: 17 busy cycles, then every digit checked.
    for (int v = 0; v < 9; v++) begin
      applyStimulus(vecs[v].value, 1'b1);
      countBusy(n);
      checkOutput($sformatf("busy len %0d", vecs[v].value), n, 17);
      checkDigits($sformatf("val %0d", vecs[v].value), vecs[v].expBcd);
    end

    // Load strobe without clk_en must be ignored.
    applyStimulus(16'd555, 1'b0);
    sawBusy = 1'b0;
    repeat (20) begin
      if (bus.o_busy) sawBusy = 1'b1;
      @(negedge clk);
    end
    checkOutput("no clk_en busy", {31'd0, sawBusy}, 32'h0);
    checkDigits("no clk_en disp", 20'h32768);

    // Load 7, then 42 and 99 during CONVERT; 42 is overwritten by 99.
    applyStimulus(16'd7, 1'b1);
    cyc   = 0;
    busyN = 0;
    saw42 = 1'b0;
    while ((bus.o_busy || cyc < 5) && cyc < 200) begin
      if (bus.o_busy) busyN++;
      if (bus.o_an === 5'b11110 && bus.o_seg === segOf(4'd2)) saw42 = 1'b1;
      if (bus.o_an === 5'b11101 && bus.o_seg === segOf(4'd4)) saw42 = 1'b1;
      case (cyc)
        2: begin
          bus.clk_en        = 1'b1;
          bus.i_load_enable = 1'b1;
          bus.i_load_data   = 16'd42;
        end
        3: bus.i_load_data = 16'd99;
        4: begin
          bus.clk_en        = 1'b0;
          bus.i_load_enable = 1'b0;
        end
        default: ;
      endcase
      @(negedge clk);
      cyc++;
    end
    checkOutput("pend busy len", busyN, 34);
    checkOutput("pend no 42", {31'd0, saw42}, 32'h0);
    checkDigits("pend final", 20'h00099);

    // Reset in the middle of a conversion.
    applyStimulus(16'd5, 1'b1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid rst seg",  {25'd0, bus.o_seg}, 32'h7F);
    checkOutput("mid rst an",   {27'd0, bus.o_an},  32'h1F);
    checkOutput("mid rst busy", {31'd0, bus.o_busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("post rst busy", {31'd0, bus.o_busy}, 32'h0);
    checkDigits("post rst", 20'h00000);

    // Scan period: digit 0 slot recurs every DIGITS*SCAN_DIV cycles.
    n = 0;
    while (bus.o_an === 5'b11110 && n < 100) begin
      @(negedge clk);
      n++;
    end
    while (bus.o_an !== 5'b11110 && n < 100) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (bus.o_an === 5'b11110 && n < 100) begin
      @(negedge clk);
      n++;
    end
    while (bus.o_an !== 5'b11110 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("scan period", n, DIGITS * SCAN_DIV);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
